pio_edge_irq: RTL and testbench

PIO_EDGE_IRQ -- requirements
Module: pio_edge_irq

---
 rtl/pio_pkg.sv | 15 +
 rtl/pio_sync_edge.sv | 39 +++
 rtl/pio_edge_irq.sv | 76 +++++++
 tb/tb_pio_edge_irq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared register map and capture-edge encodings for the edge-capturing PIO.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd1;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
  localparam logic [2:0] ADDR_OUT_RB   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// One input bit: two-flop synchronizer, a history flop, and the selected edge detector.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic out_sync,
  output logic out_edge
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= in_bit;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_comb begin
    out_edge = 1'b0;
    case (EDGE_TYPE)
      EDGE_RISE: out_edge = r_s2 & ~r_s3;
      EDGE_FALL: out_edge = ~r_s2 & r_s3;
      default:   out_edge = r_s2 ^ r_s3;
    endcase
  end

  assign out_sync = r_s2;

endmodule

// File: rtl/pio_edge_irq.sv
// Avalon-MM PIO with set/clear outputs, sticky edge capture and a maskable level interrupt.
module pio_edge_irq
  import pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int          EDGE_TYPE   = EDGE_RISE,
  parameter int          IRQ_EN      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect,
  input  logic [2:0]            address,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] r_out, r_mask, r_cap;
  logic [DATA_WIDTH-1:0] w_sync, w_edge, w_wd, w_clr;
  logic [1:0]            r_arm;
  logic                  w_wr, w_armed;
  logic                  w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_wd        = writedata[DATA_WIDTH-1:0];
  assign w_unused_wd = ^writedata;
  assign w_armed     = (r_arm == 2'd3);
  assign w_clr       = (w_wr && address == ADDR_EDGE_CAP) ? w_wd : '0;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    pio_sync_edge #(.EDGE_TYPE(EDGE_TYPE)) u_sync_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit  (in_port[i]),
      .out_sync(w_sync[i]),
      .out_edge(w_edge[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out  <= RESET_VALUE[DATA_WIDTH-1:0];
      r_mask <= '0;
      r_cap  <= '0;
      r_arm  <= 2'd0;
    end else begin
      // Edge detection stays off until the synchronizer has refilled after reset.
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
      if (w_wr && address == ADDR_DATA)          r_out <= w_wd;
      else if (w_wr && address == ADDR_OUTSET)   r_out <= r_out | w_wd;
      else if (w_wr && address == ADDR_OUTCLEAR) r_out <= r_out & ~w_wd;
      if (IRQ_EN != 0 && w_wr && address == ADDR_IRQ_MASK) r_mask <= w_wd;
      // A new edge outranks a simultaneous write-1-to-clear.
      r_cap <= (r_cap & ~w_clr) | (w_armed ? w_edge : '0);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[DATA_WIDTH-1:0] = w_sync;
      ADDR_IRQ_MASK: readdata[DATA_WIDTH-1:0] = r_mask;
      ADDR_EDGE_CAP: readdata[DATA_WIDTH-1:0] = r_cap;
      ADDR_OUT_RB:   readdata[DATA_WIDTH-1:0] = r_out;
      default:       readdata = '0;
    endcase
  end

  assign out_port = r_out;
  assign irq      = (IRQ_EN != 0) ? |(r_cap & r_mask) : 1'b0;

endmodule

// File: tb/tb_pio_edge_irq.sv
// Three PIO configurations on a shared bus, checked against a sample-history reference model.
module tb_pio_edge_irq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs0, cs1, cs2;
  logic [7:0]  in0, in1;
  logic [4:0]  in2;
  logic [31:0] rd0, rd1, rd2;
  logic [7:0]  out0, out1;
  logic [4:0]  out2;
  logic        irq0, irq1, irq2;

  pio_edge_irq #(.DATA_WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0), .IRQ_EN(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs0), .address(address), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in0), .out_port(out0), .irq(irq0));
  pio_edge_irq #(.DATA_WIDTH(8), .RESET_VALUE(32'h00), .EDGE_TYPE(2), .IRQ_EN(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs1), .address(address), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .in_port(in1), .out_port(out1), .irq(irq1));
  pio_edge_irq #(.DATA_WIDTH(5), .RESET_VALUE(32'h00), .EDGE_TYPE(1), .IRQ_EN(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs2), .address(address), .write_n(write_n),
    .writedata(writedata), .readdata(rd2), .in_port(in2), .out_port(out2), .irq(irq2));

  // Reference model: registers plus the last three sampled input values per instance.
  logic [7:0] m_out[3], m_mask[3], m_cap[3];
  logic [7:0] h_a[3], h_b[3], h_c[3];
  int         m_n[3];
  logic [7:0] wm[3]  = '{8'hFF, 8'hFF, 8'h1F};
  logic [7:0] rv[3]  = '{8'hA5, 8'h00, 8'h00};
  int         et[3]  = '{0, 2, 1};
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] cur_in(input int d);
    return (d == 0) ? in0 : (d == 1) ? in1 : {3'b000, in2};
  endfunction
  function automatic logic cur_cs(input int d);
    return (d == 0) ? cs0 : (d == 1) ? cs1 : cs2;
  endfunction
  function automatic logic [31:0] cur_rd(input int d);
    return (d == 0) ? rd0 : (d == 1) ? rd1 : rd2;
  endfunction
  function automatic logic [7:0] cur_out(input int d);
    return (d == 0) ? out0 : (d == 1) ? out1 : {3'b000, out2};
  endfunction
  function automatic logic cur_irq(input int d);
    return (d == 0) ? irq0 : (d == 1) ? irq1 : irq2;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [2:0] a);
    case (a)
      3'd0:    return {24'b0, h_b[d]};
      3'd1:    return {24'b0, m_mask[d]};
      3'd2:    return {24'b0, m_cap[d]};
      3'd3:    return {24'b0, m_out[d]};
      default: return 32'b0;
    endcase
  endfunction

  // Edge n (counted from reset release) records transitions between samples n-3 and n-2,
  // but only from the fourth edge on.
  task automatic model_step();
    logic [7:0] e, wd, clr;
    for (int d = 0; d < 3; d++) begin
      if (!reset_n) begin
        m_out[d] = rv[d]; m_mask[d] = 8'h00; m_cap[d] = 8'h00;
        h_a[d] = 8'h00; h_b[d] = 8'h00; h_c[d] = 8'h00; m_n[d] = 0;
      end else begin
        if (m_n[d] < 100) m_n[d]++;
        if (et[d] == 0)      e = h_b[d] & ~h_c[d];
        else if (et[d] == 1) e = ~h_b[d] & h_c[d];
        else                 e = h_b[d] ^ h_c[d];
        e   = e & wm[d];
        wd  = writedata[7:0] & wm[d];
        clr = 8'h00;
        if (cur_cs(d) && !write_n) begin
          case (address)
            3'd0: m_out[d] = wd;
            3'd1: m_mask[d] = wd;
            3'd2: clr = wd;
            3'd4: m_out[d] = m_out[d] | wd;
            3'd5: m_out[d] = m_out[d] & ~wd;
            default: ;
          endcase
        end
        m_cap[d] = (m_cap[d] & ~clr) | ((m_n[d] >= 4) ? e : 8'h00);
        h_c[d] = h_b[d]; h_b[d] = h_a[d]; h_a[d] = cur_in(d) & wm[d];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("out%0d", d), {24'b0, cur_out(d)}, {24'b0, m_out[d]});
      chk($sformatf("irq%0d", d), {31'b0, cur_irq(d)}, {31'b0, |(m_cap[d] & m_mask[d])});
    end
  endtask

  task automatic cyc(input logic [2:0] csv, input logic [2:0] a, input logic wr, input logic [31:0] wd);
    cs0 = csv[0]; cs1 = csv[1]; cs2 = csv[2];
    address = a; write_n = ~wr; writedata = wd;
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("rd%0d_a%0d", d, a), cur_rd(d), model_read(d, a));
    tick();
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0; write_n = 1'b1;
  endtask

  task automatic peek(input logic [2:0] a);
    address = a; write_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; write_n = 1'b1; writedata = 32'h0;
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    in0 = 8'hFF; in1 = 8'hFF; in2 = 5'h1F;
    repeat (3) tick();
    chk("rst_out0", {24'b0, out0}, 32'hA5);
    chk("rst_irq", {29'b0, irq0, irq1, irq2}, 32'h0);
    reset_n = 1'b1;

    // Inputs held high through release: nothing may be captured.
    for (int i = 0; i < 10; i++) cyc(3'b000, 3'd2, 1'b0, 32'h0);
    peek(3'd2);
    chk("arm_cap0", rd0, 32'h0);
    chk("arm_cap1", rd1, 32'h0);
    peek(3'd3);
    chk("rv_outrb", rd0, 32'hA5);

    cyc(3'b001, 3'd4, 1'b1, 32'h0F);
    cyc(3'b001, 3'd5, 1'b1, 32'hA0);
    chk("setclr_out0", {24'b0, out0}, 32'h0F);
    cyc(3'b001, 3'd3, 1'b1, 32'hFF);
    chk("outrb_ro", {24'b0, out0}, 32'h0F);

    // Rising capture on bit 0 of instance 0.
    in0 = 8'h00;
    repeat (4) cyc(3'b000, 3'd0, 1'b0, 32'h0);
    cyc(3'b001, 3'd1, 1'b1, 32'h01);
    in0 = 8'h01;
    cyc(3'b000, 3'd2, 1'b0, 32'h0);
    cyc(3'b000, 3'd2, 1'b0, 32'h0);
    chk("rise_k1_irq", {31'b0, irq0}, 32'h0);
    cyc(3'b000, 3'd2, 1'b0, 32'h0);
    chk("rise_k2_irq", {31'b0, irq0}, 32'h1);
    peek(3'd2);
    chk("rise_cap", rd0, 32'h01);
    in0 = 8'h00;
    repeat (4) cyc(3'b000, 3'd2, 1'b0, 32'h0);
    peek(3'd2);
    chk("fall_nocap", rd0, 32'h01);

    // Clear colliding with a fresh edge on the same bit.
    in0 = 8'h01;
    cyc(3'b000, 3'd2, 1'b0, 32'h0);
    cyc(3'b000, 3'd2, 1'b0, 32'h0);
    cyc(3'b001, 3'd2, 1'b1, 32'h01);
    chk("setwins_irq", {31'b0, irq0}, 32'h1);
    peek(3'd2);
    chk("setwins_cap", rd0, 32'h01);
    cyc(3'b001, 3'd2, 1'b1, 32'h01);
    peek(3'd2);
    chk("w1c_cap", rd0, 32'h0);

    // Any-edge capture with the mask closed, then opened.
    in1 = 8'hF7;
    repeat (3) cyc(3'b000, 3'd2, 1'b0, 32'h0);
    peek(3'd2);
    chk("any_cap", rd1, 32'h08);
    chk("any_irq_masked", {31'b0, irq1}, 32'h0);
    cyc(3'b010, 3'd1, 1'b1, 32'h08);
    chk("any_irq_open", {31'b0, irq1}, 32'h1);

    // Narrow instance, reserved addresses.
    cyc(3'b100, 3'd0, 1'b1, 32'hFFFFFFFF);
    peek(3'd3);
    chk("w5_outrb", rd2, 32'h1F);
    peek(3'd6);
    chk("rsv6_rd", rd0 | rd1 | rd2, 32'h0);
    cyc(3'b111, 3'd7, 1'b1, 32'hFFFFFFFF);
    cyc(3'b111, 3'd6, 1'b1, 32'hFFFFFFFF);
    for (int a = 0; a < 4; a++) cyc(3'b000, a[2:0], 1'b0, 32'h0);

    // Randomized traffic, with one mid-run reset pulse.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) in1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) in2 = 5'($urandom);
      if (i == 200) begin
        reset_n = 1'b0;
        cyc(3'b111, 3'($urandom_range(0, 7)), 1'b1, $urandom);
        chk("midrst_irq", {29'b0, irq0, irq1, irq2}, 32'h0);
        reset_n = 1'b1;
      end else begin
        cyc(3'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4), $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
